// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the clock-monitor subsystem.
package clk_mon_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        WAIT_LOCK = 3'd2,
        SETTLE    = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } sup_state_t;

    // Saturating increment on a 64-bit carrier; callers cast to their own width.
    // A coincident clear restarts the count at 1 so the triggering event is kept.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input logic [63:0] max,
                                            input logic        clear);
        logic [63:0] r;
        if (clear)
            r = 64'd1;
        else if (value >= max)
            r = max;
        else
            r = value + 64'd1;
        return r;
    endfunction

endpackage

// File: rtl/mmcm_lock_supervisor_lock_sync.sv
// Synchroniser for the asynchronous MMCM locked flag, plus falling-edge detect.
module lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_ref,
    input  logic reset,
    input  logic locked,
    output logic lk,
    output logic lk_fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   lk_d;

    always_ff @(posedge clk_ref or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            lk_d <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], locked};
            lk_d <= sync[SYNC_STAGES-1];
        end
    end

    assign lk      = sync[SYNC_STAGES-1];
    assign lk_fall = lk_d & ~lk;

endmodule

// File: rtl/mmcm_lock_supervisor.sv
// Supervises one MMCM: reset sequencing, lock wait with bounded retries,
// settle qualification before datapath release, and lock-loss/timeout counters.
module mmcm_lock_supervisor
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 100000,
    parameter int SETTLE_CYCLES   = 1024,
    parameter int MAX_RETRIES     = 8,
    parameter int CNT_W           = 32
) (
    input  logic             clk_ref,
    input  logic             reset,
    input  logic             locked,
    input  logic             enable,
    input  logic             force_reset,
    input  logic             clear_counts,
    output logic             mmcm_rst,
    output logic             dp_rst_n,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] unlocks,
    output logic [CNT_W-1:0] timeouts
);

    // state     | meaning
    // IDLE      | disabled, MMCM held in reset
    // RESET     | MMCM reset pulse, RST_HOLD_CYCLES long
    // WAIT_LOCK | waiting for lk, bounded by LOCK_TIMEOUT
    // SETTLE    | lk must stay high SETTLE_CYCLES before release
    // RUN       | datapath released
    // FAULT     | MAX_RETRIES consecutive timeouts; needs force_reset or enable=0

    localparam int TIMER_MAX_A = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int TIMER_MAX   = (TIMER_MAX_A > SETTLE_CYCLES) ? TIMER_MAX_A : SETTLE_CYCLES;
    localparam int TIMER_W     = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam int RETRY_W     = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

    localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TO_LAST     = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRIES - 1);
    localparam logic [63:0]        CNT_MAX     = 64'({CNT_W{1'b1}});

    sup_state_t         cur;
    sup_state_t         nxt;
    logic [TIMER_W-1:0] timer;
    logic [RETRY_W-1:0] retry;
    logic               timer_clr;
    logic               retry_clr;
    logic               retry_inc;
    logic               timeout_evt;
    logic               unlock_evt;
    logic               lk;
    logic               lk_fall;
    logic [CNT_W-1:0]   unlocks_inc;
    logic [CNT_W-1:0]   timeouts_inc;

    lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_ref (clk_ref),
        .reset   (reset),
        .locked  (locked),
        .lk      (lk),
        .lk_fall (lk_fall)
    );

    always_comb begin
        nxt         = cur;
        timer_clr   = 1'b0;
        retry_clr   = 1'b0;
        retry_inc   = 1'b0;
        timeout_evt = 1'b0;
        if (!enable) begin
            nxt       = IDLE;
            retry_clr = 1'b1;
        end else if (force_reset && cur != IDLE) begin
            nxt       = RESET;
            timer_clr = 1'b1;
            retry_clr = 1'b1;
        end else begin
            case (cur)
                IDLE:      nxt = RESET;
                RESET:     if (timer == RST_LAST) nxt = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (lk) begin
                        nxt = SETTLE;
                    end else if (timer == TO_LAST) begin
                        timeout_evt = 1'b1;
                        if (retry == RETRY_LAST) begin
                            nxt = FAULT;
                        end else begin
                            nxt       = RESET;
                            retry_inc = 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    // a dropout restarts the lock wait without counting as a loss
                    if (!lk) begin
                        nxt = WAIT_LOCK;
                    end else if (timer == SETTLE_LAST) begin
                        nxt       = RUN;
                        retry_clr = 1'b1;
                    end
                end
                RUN:       if (lk_fall) nxt = RESET;
                FAULT:     nxt = FAULT;
                default:   nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clk_ref or negedge reset) begin
        if (!reset) begin
            cur      <= IDLE;
            timer    <= '0;
            retry    <= '0;
            mmcm_rst <= 1'b1;
            dp_rst_n <= 1'b0;
            fault    <= 1'b0;
        end else begin
            cur <= nxt;
            if (timer_clr || nxt != cur)
                timer <= '0;
            else if (cur inside {RESET, WAIT_LOCK, SETTLE})
                timer <= timer + 1'b1;
            if (retry_clr)
                retry <= '0;
            else if (retry_inc)
                retry <= retry + 1'b1;
            mmcm_rst <= (nxt == IDLE) || (nxt == RESET) || (nxt == FAULT);
            dp_rst_n <= (nxt == RUN);
            fault    <= (nxt == FAULT);
        end
    end

    assign unlock_evt   = (cur == RUN) && lk_fall;
    assign unlocks_inc  = CNT_W'(sat_inc(64'(unlocks), CNT_MAX, clear_counts));
    assign timeouts_inc = CNT_W'(sat_inc(64'(timeouts), CNT_MAX, clear_counts));

    always_ff @(posedge clk_ref or negedge reset) begin
        if (!reset) begin
            unlocks  <= '0;
            timeouts <= '0;
        end else begin
            if (unlock_evt)
                unlocks <= unlocks_inc;
            else if (clear_counts)
                unlocks <= '0;
            if (timeout_evt)
                timeouts <= timeouts_inc;
            else if (clear_counts)
                timeouts <= '0;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_mmcm_lock_supervisor.sv
// Directed bench for mmcm_lock_supervisor: hand sequences for latency and reset
// corners, a vector table for the long sequencing/counter scenarios.
module tb_mmcm_lock_supervisor;

    localparam int SYNC   = 2;
    localparam int HOLD   = 4;
    localparam int TO     = 20;
    localparam int SETTLE = 8;
    localparam int RETR   = 3;
    localparam int CW     = 2;   // narrow counters so saturation is reachable

    localparam int S_IDLE = 0, S_RESET = 1, S_WAIT = 2, S_SETTLE = 3, S_RUN = 4, S_FAULT = 5;

    logic          clk_ref = 1'b0;
    logic          reset;
    logic          locked;
    logic          enable;
    logic          force_reset;
    logic          clear_counts;
    logic          mmcm_rst;
    logic          dp_rst_n;
    logic          fault;
    logic [2:0]    state;
    logic [CW-1:0] unlocks;
    logic [CW-1:0] timeouts;
    bit            clk_run = 1'b1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int   n;
        bit   en, frc, clr, lck;
        int   st;
        bit   mr, dp, flt;
        int   unl, tmo;
    } vec_t;

    vec_t tbl[$];

    mmcm_lock_supervisor #(
        .SYNC_STAGES     (SYNC),
        .RST_HOLD_CYCLES (HOLD),
        .LOCK_TIMEOUT    (TO),
        .SETTLE_CYCLES   (SETTLE),
        .MAX_RETRIES     (RETR),
        .CNT_W           (CW)
    ) dut (
        .clk_ref      (clk_ref),
        .reset        (reset),
        .locked       (locked),
        .enable       (enable),
        .force_reset  (force_reset),
        .clear_counts (clear_counts),
        .mmcm_rst     (mmcm_rst),
        .dp_rst_n     (dp_rst_n),
        .fault        (fault),
        .state        (state),
        .unlocks      (unlocks),
        .timeouts     (timeouts)
    );

    always begin
        #5;
        if (clk_run) clk_ref = ~clk_ref;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_ref);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int st, input int mr, input int dp,
                            input int flt, input int unl, input int tmo);
        chk({tag, " state"}, int'(state), st);
        chk({tag, " mmcm_rst"}, int'(mmcm_rst), mr);
        chk({tag, " dp_rst_n"}, int'(dp_rst_n), dp);
        chk({tag, " fault"}, int'(fault), flt);
        chk({tag, " unlocks"}, int'(unlocks), unl);
        chk({tag, " timeouts"}, int'(timeouts), tmo);
    endtask

    function automatic vec_t mk(int n, bit en, bit frc, bit clr, bit lck, int st,
                                bit mr, bit dp, bit flt, int unl, int tmo);
        vec_t v;
        v.n = n; v.en = en; v.frc = frc; v.clr = clr; v.lck = lck;
        v.st = st; v.mr = mr; v.dp = dp; v.flt = flt; v.unl = unl; v.tmo = tmo;
        return v;
    endfunction

    initial begin
        int n;
        int cnt;

        // Rows start right after the first lock loss: RESET, timer 0, locked raised.
        //            n  en f  c  lk  state     mr dp flt unl tmo
        tbl.push_back(mk(3, 1, 0, 0, 1, S_RESET,  1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, S_WAIT,   0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, S_SETTLE, 0, 0, 0, 1, 0));
        tbl.push_back(mk(7, 1, 0, 0, 1, S_SETTLE, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, S_RUN,    0, 1, 0, 1, 0));
        // loss, then three timeouts into FAULT
        tbl.push_back(mk(3, 1, 0, 0, 0, S_RESET,  1, 0, 0, 2, 0));
        tbl.push_back(mk(4, 1, 0, 0, 0, S_WAIT,   0, 0, 0, 2, 0));
        tbl.push_back(mk(19, 1, 0, 0, 0, S_WAIT,  0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, S_RESET,  1, 0, 0, 2, 1));
        tbl.push_back(mk(4, 1, 0, 0, 0, S_WAIT,   0, 0, 0, 2, 1));
        tbl.push_back(mk(20, 1, 0, 0, 0, S_RESET, 1, 0, 0, 2, 2));
        tbl.push_back(mk(4, 1, 0, 0, 0, S_WAIT,   0, 0, 0, 2, 2));
        tbl.push_back(mk(20, 1, 0, 0, 0, S_FAULT, 1, 0, 1, 2, 3));
        tbl.push_back(mk(5, 1, 0, 0, 0, S_FAULT,  1, 0, 1, 2, 3));
        tbl.push_back(mk(1, 1, 1, 0, 0, S_RESET,  1, 0, 0, 2, 3));
        tbl.push_back(mk(4, 1, 0, 0, 0, S_WAIT,   0, 0, 0, 2, 3));
        // retry cleared by force_reset: next timeout retries; timeouts saturated
        tbl.push_back(mk(20, 1, 0, 0, 0, S_RESET, 1, 0, 0, 2, 3));
        // glitch late in SETTLE: dropout wins over the terminal count
        tbl.push_back(mk(4, 1, 0, 0, 1, S_WAIT,   0, 0, 0, 2, 3));
        tbl.push_back(mk(1, 1, 0, 0, 1, S_SETTLE, 0, 0, 0, 2, 3));
        tbl.push_back(mk(5, 1, 0, 0, 1, S_SETTLE, 0, 0, 0, 2, 3));
        tbl.push_back(mk(2, 1, 0, 0, 0, S_SETTLE, 0, 0, 0, 2, 3));
        tbl.push_back(mk(1, 1, 0, 0, 0, S_WAIT,   0, 0, 0, 2, 3));
        tbl.push_back(mk(3, 1, 0, 0, 1, S_SETTLE, 0, 0, 0, 2, 3));
        tbl.push_back(mk(8, 1, 0, 0, 1, S_RUN,    0, 1, 0, 2, 3));
        // unlock saturation
        tbl.push_back(mk(3, 1, 0, 0, 0, S_RESET,  1, 0, 0, 3, 3));
        tbl.push_back(mk(13, 1, 0, 0, 1, S_RUN,   0, 1, 0, 3, 3));
        tbl.push_back(mk(3, 1, 0, 0, 0, S_RESET,  1, 0, 0, 3, 3));
        tbl.push_back(mk(13, 1, 0, 0, 1, S_RUN,   0, 1, 0, 3, 3));
        // clear_counts on the same edge as a loss
        tbl.push_back(mk(2, 1, 0, 0, 0, S_RUN,    0, 1, 0, 3, 3));
        tbl.push_back(mk(1, 1, 0, 1, 0, S_RESET,  1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, S_RESET,  1, 0, 0, 1, 0));
        tbl.push_back(mk(12, 1, 0, 0, 1, S_RUN,   0, 1, 0, 1, 0));
        // enable low in RUN
        tbl.push_back(mk(1, 0, 0, 0, 1, S_IDLE,   1, 0, 0, 1, 0));
        tbl.push_back(mk(2, 0, 0, 0, 1, S_IDLE,   1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, S_RESET,  1, 0, 0, 1, 0));

        reset        = 1'b0;
        enable       = 1'b1;
        locked       = 1'b0;
        force_reset  = 1'b0;
        clear_counts = 1'b0;
        #12;
        chk_outs("reset", S_IDLE, 1, 0, 0, 0, 0);

        // Bring-up: count the MMCM reset pulse, raise locked at cycle 10.
        @(posedge clk_ref);
        #1;
        reset = 1'b1;
        n   = 0;
        cnt = 0;
        while (int'(state) != S_WAIT && n < 30) begin
            step(1);
            n++;
            if (mmcm_rst && int'(state) == S_RESET) cnt++;
        end
        chk("bringup mmcm_rst cycles", cnt, HOLD);
        chk("bringup mmcm_rst low", int'(mmcm_rst), 0);
        while (n < 9) begin
            step(1);
            n++;
        end
        locked = 1'b1;
        n = 0;
        while (!dp_rst_n && n < 40) begin
            step(1);
            n++;
        end
        chk("bringup locked-to-dp edges", n, SYNC + SETTLE + 1);
        chk("bringup state", int'(state), S_RUN);
        chk("bringup unlocks", int'(unlocks), 0);
        chk("bringup mmcm_rst", int'(mmcm_rst), 0);

        // Lock loss in RUN: dp_rst_n must fall within SYNC+2 edges.
        locked = 1'b0;
        n = 0;
        while (dp_rst_n && n < 10) begin
            step(1);
            n++;
        end
        checks++;
        if (n < 1 || n > SYNC + 2) begin
            errors++;
            $display("FAIL loss latency: got %0d edges, required 1..%0d", n, SYNC + 2);
        end
        chk("loss unlocks", int'(unlocks), 1);
        chk("loss state", int'(state), S_RESET);
        locked = 1'b1;

        foreach (tbl[i]) begin
            enable       = tbl[i].en;
            force_reset  = tbl[i].frc;
            clear_counts = tbl[i].clr;
            locked       = tbl[i].lck;
            step(tbl[i].n);
            chk_outs($sformatf("row%0d", i), tbl[i].st, int'(tbl[i].mr), int'(tbl[i].dp),
                     int'(tbl[i].flt), tbl[i].unl, tbl[i].tmo);
        end

        // Async reset mid-WAIT_LOCK with the clock stopped.
        enable       = 1'b1;
        force_reset  = 1'b0;
        clear_counts = 1'b0;
        locked       = 1'b0;
        step(4);
        chk("pre-areset state", int'(state), S_WAIT);
        step(20);
        chk("pre-areset timeout state", int'(state), S_RESET);
        chk("pre-areset timeouts", int'(timeouts), 1);
        step(7);
        chk("pre-areset wait", int'(state), S_WAIT);
        clk_run = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_outs("areset", S_IDLE, 1, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("post-areset state", int'(state), S_IDLE);
        clk_run = 1'b1;
        step(1);
        chk("restart state", int'(state), S_RESET);
        chk("restart mmcm_rst", int'(mmcm_rst), 1);
        step(HOLD);
        chk("restart wait", int'(state), S_WAIT);
        chk("restart mmcm_rst low", int'(mmcm_rst), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
